// File: rtl/dct_mac_descale.sv
// DCT dot-product accumulator with round-half-up descale and output saturation.
// One product per cycle in; one descaled term per N_TAPS products out through a valid/ready register.
module dct_mac_descale #(
  parameter int PROD_WIDTH = 29,
  parameter int ACC_WIDTH  = 32,
  parameter int N_TAPS     = 8,
  parameter int SHIFT      = 13,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clr,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [OUT_WIDTH-1:0]  out_dout,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  localparam logic signed [ACC_WIDTH:0] HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [PROD_WIDTH-1:0] p);
    return {{(ACC_WIDTH - PROD_WIDTH){p[PROD_WIDTH-1]}}, p};
  endfunction

  // One guard bit above the accumulator so adding the half-LSB can never wrap.
  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] full);
    logic signed [ACC_WIDTH:0] t;
    t = $signed({full[ACC_WIDTH-1], full}) + HALF;
    return t >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH:0] r);
    if (r > OUT_MAX) return {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    if (r < OUT_MIN) return {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic        [CNT_W-1:0]     cnt;
  logic signed [ACC_WIDTH-1:0] full_p0;
  logic        [OUT_WIDTH:0]   res_p0;
  logic                        last_tap;
  logic                        accept;

  logic [OUT_WIDTH-1:0] dout_p1;
  logic                 sat_p1;
  logic                 vld_p1;

  assign last_tap   = (cnt == LAST_TAP);
  assign prod_ready = ap_rst_n & ~clr & ~(vld_p1 & ~out_ready & last_tap);
  assign accept     = prod_valid & prod_ready;

  assign full_p0 = acc_p0 + sext(prod_din);
  assign res_p0  = saturate(round_shift(full_p0));

  // Stage p0: accumulate taps of the current group
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_p0 <= '0;
      cnt    <= '0;
    end else if (clr) begin
      acc_p0 <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (last_tap) begin
        acc_p0 <= '0;
        cnt    <= '0;
      end else begin
        acc_p0 <= full_p0;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage p1: one-entry result register; a new load may replace a draining result
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_p1 <= '0;
      sat_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (accept && last_tap) begin
      dout_p1 <= res_p0[OUT_WIDTH-1:0];
      sat_p1  <= res_p0[OUT_WIDTH];
      vld_p1  <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_dout  = dout_p1;
  assign out_sat   = sat_p1;
  assign out_valid = vld_p1;

endmodule
